// File: rtl/icache_refill_pkg.sv
// Shared definitions for the I-cache line refill engine: FSM state
// encodings, data-word width and counter-width helpers.
package icache_refill_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam int WORD_W = 32;

   // Width of the per-word wait counter; at least one bit even when MEM_WAIT is 0.
   function automatic int wait_width(input int mem_wait);
      return (mem_wait > 0) ? $clog2(mem_wait + 1) : 1;
   endfunction

   // Total line width in bits for a given number of words per line.
   function automatic int line_width(input int words);
      return WORD_W * words;
   endfunction

endpackage

// File: rtl/icache_refill.sv
// icache_refill: on an I-cache miss, fetches one full line from the
// word-addressed instruction memory as single-word reads and hands the
// assembled line to the cache over a valid/ready response handshake.
// Optional build macro CRITICAL_WORD_FIRST_EN: the fetch starts at the
// requested word and wraps, and a crit_valid pulse marks its capture.
module icache_refill
   import icache_refill_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int WORDS_PER_LINE = 4,
   parameter int MEM_WAIT       = 1
)(
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic [ADDR_W-1:0]                   req_addr,
   output logic                                resp_valid,
   input  logic                                resp_ready,
   output logic [ADDR_W-1:0]                   resp_base,
   output logic [line_width(WORDS_PER_LINE)-1:0] resp_line,
   output logic [WORD_W-1:0]                   resp_word,
   output logic                                mem_ren,
   output logic                                mem_wen,
   output logic [ADDR_W-1:0]                   mem_addr,
   input  logic [WORD_W-1:0]                   mem_dout
`ifdef CRITICAL_WORD_FIRST_EN
   ,
   output logic                                crit_valid
`endif
);

   localparam int OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int WAIT_W = wait_width(MEM_WAIT);

   state_t                               state_r;
   state_t                               state_s;
   logic [ADDR_W-1:0]                    base_r;
   logic [OFF_W-1:0]                     req_off_r;
   logic [OFF_W-1:0]                     cur_off_r;
   logic [OFF_W-1:0]                     word_cnt_r;
   logic [WAIT_W-1:0]                    wait_cnt_r;
   logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_r;
   logic [OFF_W-1:0]                     start_off_s;
   logic                                 accept_s;
   logic                                 capture_s;
   logic                                 last_s;

   assign accept_s  = req_valid && (state_r == IDLE);
   assign capture_s = (state_r == FETCH) && (wait_cnt_r == WAIT_W'(MEM_WAIT));
   assign last_s    = capture_s && (word_cnt_r == OFF_W'(WORDS_PER_LINE - 1));

`ifdef CRITICAL_WORD_FIRST_EN
   assign start_off_s = req_addr[OFF_W-1:0];
`else
   assign start_off_s = {OFF_W{1'b0}};
`endif

   // The base keeps its offset bits zero, so line addresses never carry out of the line.
   assign resp_base = base_r;
   assign resp_line = line_r;
   assign resp_word = line_r[req_off_r];
   assign mem_wen   = 1'b0;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = FETCH;
            else          state_s = IDLE;
         end
         FETCH: begin
            if (last_s) state_s = RESP;
            else        state_s = FETCH;
         end
         RESP: begin
            if (resp_ready) state_s = IDLE;
            else            state_s = RESP;
         end
         default: state_s = IDLE;
      endcase
   end

   // Handshake and memory-port outputs decoded from the current state and offset.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_ren    = 1'b0;
      mem_addr   = {ADDR_W{1'b0}};
      case (state_r)
         IDLE:  req_ready = 1'b1;
         FETCH: begin
            mem_ren  = 1'b1;
            mem_addr = {base_r[ADDR_W-1:OFF_W], cur_off_r};
         end
         RESP:  resp_valid = 1'b1;
         default: req_ready = 1'b0;
      endcase
   end

   // Request latch, wait/word counters and line buffer capture.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         base_r     <= {ADDR_W{1'b0}};
         req_off_r  <= {OFF_W{1'b0}};
         cur_off_r  <= {OFF_W{1'b0}};
         word_cnt_r <= {OFF_W{1'b0}};
         wait_cnt_r <= {WAIT_W{1'b0}};
         line_r     <= {(WORDS_PER_LINE*WORD_W){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  base_r     <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  req_off_r  <= req_addr[OFF_W-1:0];
                  cur_off_r  <= start_off_s;
                  word_cnt_r <= {OFF_W{1'b0}};
                  wait_cnt_r <= {WAIT_W{1'b0}};
               end
            end
            FETCH: begin
               if (capture_s) begin
                  line_r[cur_off_r] <= mem_dout;
                  cur_off_r         <= cur_off_r + OFF_W'(1);
                  word_cnt_r        <= word_cnt_r + OFF_W'(1);
                  wait_cnt_r        <= {WAIT_W{1'b0}};
               end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
               end
            end
            default: begin
               wait_cnt_r <= {WAIT_W{1'b0}};
            end
         endcase
      end
   end

`ifdef CRITICAL_WORD_FIRST_EN
   logic crit_r;

   // One-cycle pulse following the edge that captures the first (requested) word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         crit_r <= 1'b0;
      end else begin
         crit_r <= capture_s && (word_cnt_r == {OFF_W{1'b0}});
      end
   end

   assign crit_valid = crit_r;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: a default instance (4 words,
// one wait cycle) and an 8-word zero-wait instance, both reading from a
// behavioural combinational memory array.
module tb_icache_refill;

`ifdef CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif
   localparam int MW = 1;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [31:0]  memd [0:1023];
   int           checks = 0;
   int           errors = 0;

   logic         req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0;
   logic [9:0]   req_addr = 10'd0, resp_base, mem_addr;
   logic [127:0] resp_line;
   logic [31:0]  resp_word, mem_dout;
   logic         mem_ren, mem_wen, crit_valid;

   logic         req_valid8 = 1'b0, req_ready8, resp_valid8, resp_ready8 = 1'b0;
   logic [9:0]   req_addr8 = 10'd0, resp_base8, mem_addr8;
   logic [255:0] resp_line8;
   logic [31:0]  resp_word8, mem_dout8;
   logic         mem_ren8, mem_wen8, crit_valid8;

   logic [9:0]   obs_addr[$];
   int           crit_n[$];
   int           obs_lat;
   bit           obs_timeout;

   assign mem_dout  = memd[mem_addr];
   assign mem_dout8 = memd[mem_addr8];

   always #5 clock = ~clock;

   icache_refill #(.ADDR_W(10), .WORDS_PER_LINE(4), .MEM_WAIT(MW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_base(resp_base),
      .resp_line(resp_line), .resp_word(resp_word),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout)
`ifdef CRITICAL_WORD_FIRST_EN
      , .crit_valid(crit_valid)
`endif
   );

   icache_refill #(.ADDR_W(10), .WORDS_PER_LINE(8), .MEM_WAIT(0)) dut8 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid8), .req_ready(req_ready8), .req_addr(req_addr8),
      .resp_valid(resp_valid8), .resp_ready(resp_ready8), .resp_base(resp_base8),
      .resp_line(resp_line8), .resp_word(resp_word8),
      .mem_ren(mem_ren8), .mem_wen(mem_wen8), .mem_addr(mem_addr8), .mem_dout(mem_dout8)
`ifdef CRITICAL_WORD_FIRST_EN
      , .crit_valid(crit_valid8)
`endif
   );

`ifndef CRITICAL_WORD_FIRST_EN
   assign crit_valid  = 1'b0;
   assign crit_valid8 = 1'b0;
`endif

   // Write enable must never be asserted by either instance.
   always @(negedge clock) begin
      checks++;
      if (mem_wen !== 1'b0 || mem_wen8 !== 1'b0) begin
         errors++;
         $display("FAIL mem_wen: got %b/%b, required 0/0", mem_wen, mem_wen8);
      end
   end

   // Reference: word address of the k-th word fetched for request a.
   function automatic logic [9:0] model_addr(input int a, input int k, input int wpl);
      int base;
      int start;
      base  = a - (a % wpl);
      start = CWF ? (a % wpl) : 0;
      return 10'(base + ((start + k) % wpl));
   endfunction

   // Reference: the 4-word line holding address a, as currently in memory.
   function automatic logic [127:0] model_line4(input int a);
      logic [127:0] l;
      int base;
      base = a - (a % 4);
      for (int k = 0; k < 4; k++) l[32*k +: 32] = memd[base + k];
      return l;
   endfunction

   // Drive one request into the default instance and record what it does until resp_valid.
   task automatic run_req(input logic [9:0] a);
      obs_addr.delete();
      crit_n.delete();
      obs_timeout = 1'b1;
      obs_lat     = -1;
      req_valid   = 1'b1;
      req_addr    = a;
      @(posedge clock);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (n == 1) req_valid = 1'b0;
         if (crit_valid === 1'b1) crit_n.push_back(n);
         if (resp_valid === 1'b1) begin
            obs_lat     = n - 1;
            obs_timeout = 1'b0;
            break;
         end
         if (mem_ren === 1'b1) obs_addr.push_back(mem_addr);
      end
   endtask

   // Complete the response handshake; returns at a negedge in IDLE.
   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_ren !== 1'b0 || mem_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset_ctrl: rdy=%b vld=%b ren=%b addr=%h, required 1 0 0 000", req_ready, resp_valid, mem_ren, mem_addr);
      end
      checks++;
      if (resp_base !== 10'd0 || resp_line !== 128'd0 || resp_word !== 32'd0 || crit_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: base=%h line=%h word=%h, required zeros", resp_base, resp_line, resp_word);
      end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic();
      bit bad;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready: got %b, required 1", req_ready);
      end
      run_req(10'h013);
      checks++;
      if (obs_timeout || obs_lat != 4 * (MW + 1)) begin
         errors++;
         $display("FAIL basic_latency: got %0d (timeout=%0b), required %0d", obs_lat, obs_timeout, 4 * (MW + 1));
      end
      bad = (obs_addr.size() != 4 * (MW + 1));
      for (int i = 0; i < obs_addr.size() && !bad; i++)
         if (obs_addr[i] !== model_addr(32'h013, i / (MW + 1), 4)) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL basic_addr_seq: got %0d entries first=%h, required %0d entries first=%h", obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 10'h0, 4 * (MW + 1), model_addr(32'h013, 0, 4));
      end
      checks++;
      if (resp_line !== 128'h10000013_10000012_10000011_10000010) begin
         errors++;
         $display("FAIL basic_line: got %h, required 10000013100000121000001110000010", resp_line);
      end
      checks++;
      if (resp_base !== 10'h010 || resp_word !== 32'h1000_0013) begin
         errors++;
         $display("FAIL basic_base_word: got %h/%h, required 010/10000013", resp_base, resp_word);
      end
      checks++;
      if (mem_ren !== 1'b0 || mem_addr !== 10'd0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_resp_state: ren=%b addr=%h rdy=%b, required 0 000 0", mem_ren, mem_addr, req_ready);
      end
`ifdef CRITICAL_WORD_FIRST_EN
      checks++;
      if (crit_n.size() != 1 || crit_n[0] != MW + 2) begin
         errors++;
         $display("FAIL basic_crit: got %0d pulses first at %0d, required 1 at %0d", crit_n.size(), (crit_n.size() > 0) ? crit_n[0] : -1, MW + 2);
      end
`endif
      finish_resp();
   endtask

   task automatic test_backpressure();
      logic [127:0] snap_line;
      logic [9:0]   snap_base;
      bit           bad;
      run_req(10'h013);
      snap_line = model_line4(32'h013);
      snap_base = 10'h010;
      req_valid = 1'b1;
      req_addr  = 10'h020;
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (resp_valid !== 1'b1 || resp_line !== snap_line || resp_base !== snap_base || req_ready !== 1'b0 || mem_ren !== 1'b0) bad = 1'b1;
         @(negedge clock);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL hold_resp: vld=%b base=%h rdy=%b ren=%b, required stable 1 010 0 0", resp_valid, resp_base, req_ready, mem_ren);
      end
      finish_resp();
      checks++;
      if (req_ready !== 1'b1 || mem_ren !== 1'b0) begin
         errors++;
         $display("FAIL hold_no_accept: rdy=%b ren=%b, required 1 0", req_ready, mem_ren);
      end
      run_req(10'h020);
      checks++;
      if (obs_timeout || obs_lat != 4 * (MW + 1) || obs_addr.size() == 0 || obs_addr[0] !== model_addr(32'h020, 0, 4)) begin
         errors++;
         $display("FAIL hold_next_req: lat=%0d timeout=%0b, required %0d", obs_lat, obs_timeout, 4 * (MW + 1));
      end
      checks++;
      if (resp_line !== model_line4(32'h020) || resp_base !== 10'h020 || resp_word !== memd[32]) begin
         errors++;
         $display("FAIL hold_next_line: got %h base %h, required %h base 020", resp_line, resp_base, model_line4(32'h020));
      end
      finish_resp();
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1;
      req_addr  = 10'h013;
      @(posedge clock);
      for (int n = 1; n <= 3; n++) begin
         @(negedge clock);
         req_valid = 1'b0;
      end
      checks++;
      if (mem_ren !== 1'b1) begin
         errors++;
         $display("FAIL mid_fetching: ren=%b, required 1", mem_ren);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (mem_ren !== 1'b0 || resp_valid !== 1'b0 || resp_line !== 128'd0 || mem_addr !== 10'd0) begin
         errors++;
         $display("FAIL mid_reset: ren=%b vld=%b line=%h addr=%h, required 0 0 0 000", mem_ren, resp_valid, resp_line, mem_addr);
      end
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_ready: got %b, required 1", req_ready);
      end
      run_req(10'h005);
      checks++;
      if (obs_timeout || obs_lat != 4 * (MW + 1) || resp_line !== model_line4(32'h005) || resp_word !== memd[5] || resp_base !== 10'h004) begin
         errors++;
         $display("FAIL mid_recover: lat=%0d line=%h word=%h, required %0d %h %h", obs_lat, resp_line, resp_word, 4 * (MW + 1), model_line4(32'h005), memd[5]);
      end
      finish_resp();
   endtask

   task automatic test_top_line();
      bit bad;
      run_req(10'h3FF);
      bad = (obs_addr.size() != 4 * (MW + 1));
      for (int i = 0; i < obs_addr.size(); i++)
         if (obs_addr[i] < 10'h3FC || obs_addr[i] !== model_addr(32'h3FF, i / (MW + 1), 4)) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL top_addr_range: got %0d entries, required %0d within 3FC-3FF", obs_addr.size(), 4 * (MW + 1));
      end
      checks++;
      if (resp_base !== 10'h3FC || resp_word !== 32'h1000_03FF || resp_line !== 128'h100003FF_100003FE_100003FD_100003FC) begin
         errors++;
         $display("FAIL top_result: base=%h word=%h line=%h, required 3FC 100003FF", resp_base, resp_word, resp_line);
      end
      finish_resp();
   endtask

   task automatic test_wpl8();
      logic [9:0]   seq[$];
      int           cn[$];
      int           lat;
      int           a;
      bit           bad;
      logic [255:0] exp_line;
      a   = 32'h0A5;
      lat = -1;
      checks++;
      if (req_ready8 !== 1'b1) begin
         errors++;
         $display("FAIL w8_ready: got %b, required 1", req_ready8);
      end
      req_valid8 = 1'b1;
      req_addr8  = 10'(a);
      @(posedge clock);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (n == 1) req_valid8 = 1'b0;
         if (crit_valid8 === 1'b1) cn.push_back(n);
         if (resp_valid8 === 1'b1) begin
            lat = n - 1;
            break;
         end
         if (mem_ren8 === 1'b1) seq.push_back(mem_addr8);
      end
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL w8_latency: got %0d, required 8", lat);
      end
      bad = (seq.size() != 8);
      for (int i = 0; i < seq.size() && !bad; i++)
         if (seq[i] !== model_addr(a, i, 8)) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL w8_addr_seq: got %0d entries, required 8 changing every cycle", seq.size());
      end
      for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = memd[160 + k];
      checks++;
      if (resp_line8 !== exp_line || resp_base8 !== 10'h0A0 || resp_word8 !== memd[a]) begin
         errors++;
         $display("FAIL w8_result: base=%h word=%h, required 0A0 %h", resp_base8, resp_word8, memd[a]);
      end
`ifdef CRITICAL_WORD_FIRST_EN
      checks++;
      if (cn.size() != 1 || cn[0] != 2) begin
         errors++;
         $display("FAIL w8_crit: got %0d pulses, required 1 at cycle 2", cn.size());
      end
`endif
      resp_ready8 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      resp_ready8 = 1'b0;
   endtask

   task automatic test_random();
      logic [9:0] a;
      bit         bad;
      for (int i = 0; i < 1024; i++) memd[i] = $urandom;
      for (int t = 0; t < 8; t++) begin
         a = 10'($urandom_range(0, 1023));
         run_req(a);
         bad = (obs_addr.size() != 4 * (MW + 1));
         for (int i = 0; i < obs_addr.size() && !bad; i++)
            if (obs_addr[i] !== model_addr(int'(a), i / (MW + 1), 4)) bad = 1'b1;
         checks++;
         if (obs_timeout || obs_lat != 4 * (MW + 1) || bad) begin
            errors++;
            $display("FAIL rand_fetch addr=%h: lat=%0d seq_ok=%0b, required %0d 1", a, obs_lat, !bad, 4 * (MW + 1));
         end
         checks++;
         if (resp_line !== model_line4(int'(a)) || resp_word !== memd[a] || resp_base !== {a[9:2], 2'b00}) begin
            errors++;
            $display("FAIL rand_result addr=%h: line=%h word=%h, required %h %h", a, resp_line, resp_word, model_line4(int'(a)), memd[a]);
         end
         repeat ($urandom_range(0, 3)) @(negedge clock);
         finish_resp();
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) memd[i] = 32'h1000_0000 + i;
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid();
      test_top_line();
      test_wpl8();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
